// File: rtl/mem_access_unit.sv
// Purpose : memory-access pipeline stage; issues load/store requests and registers results to writeback.
// Latency : pass-through 1 cycle; store 1 cycle after grant; load 1 cycle after dmem_rvalid.
// Backpressure: ma_stall holds upstream while waiting for dmem_gnt or dmem_rvalid; BUBBLEs go to writeback meanwhile.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ma_inst/ma_pc/ma_dat/ma_rd2  instruction, PC, address (ALU result), store data from execute
//   ma_stall                     high while upstream must hold ma_* stable
//   dmem_req/we/addr/be/wdat     data-memory request (word-aligned address, byte lanes)
//   dmem_gnt/rvalid/rdat         data-memory grant and read response
//   wb_inst/wb_pc/wb_dat         registered results to writeback
//   ma_misalign                  registered misaligned-access flag
//
// Optional build macro: MA_MISALIGN_TRAP_EN -- misaligned halfword/word accesses are
// suppressed and flagged on ma_misalign instead of being performed aligned.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ma_inst,
  input  logic [31:0] ma_pc,
  input  logic [31:0] ma_dat,
  input  logic [31:0] ma_rd2,
  output logic        ma_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdat,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdat,
  output logic [31:0] wb_inst,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_dat,
  output logic        ma_misalign
);

  localparam logic [31:0] BUBBLE    = 32'h0000_0013;
  localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]  OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  state_e      state_q, state_d;
  logic [31:0] wb_inst_q, wb_inst_d;
  logic [31:0] wb_pc_q, wb_pc_d;
  logic [31:0] wb_dat_q, wb_dat_d;

  logic        is_load, is_store, is_mem, ld_unsigned, misalign;
  size_e       size;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Only opcode and funct3 matter here; the remaining instruction bits travel untouched.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{ma_inst[31:15], ma_inst[11:7]};

  assign is_load  = (ma_inst[6:0] == OPC_LOAD);
  assign is_store = (ma_inst[6:0] == OPC_STORE);
  assign is_mem   = is_load | is_store;

  // Access size; any funct3 that is not a legal size for the access type becomes a word.
  always_comb begin
    size        = SZ_W;
    ld_unsigned = 1'b0;
    if (is_load) begin
      case (ma_inst[14:12])
        3'b000:  size = SZ_B;
        3'b001:  size = SZ_H;
        3'b100:  begin size = SZ_B; ld_unsigned = 1'b1; end
        3'b101:  begin size = SZ_H; ld_unsigned = 1'b1; end
        default: size = SZ_W;
      endcase
    end else if (is_store) begin
      case (ma_inst[14:12])
        3'b000:  size = SZ_B;
        3'b001:  size = SZ_H;
        default: size = SZ_W;
      endcase
    end
  end

`ifdef MA_MISALIGN_TRAP_EN
  assign misalign = is_mem && (((size == SZ_H) && ma_dat[0]) ||
                               ((size == SZ_W) && (ma_dat[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // Request fields come straight from ma_*: upstream keeps them stable while stalled,
  // so address/lanes/data stay constant across REQ without extra holding registers.
  assign dmem_addr = {ma_dat[31:2], 2'b00};
  assign dmem_we   = dmem_req & is_store;

  always_comb begin
    dmem_be   = 4'b1111;
    dmem_wdat = ma_rd2;
    case (size)
      SZ_B: begin
        dmem_be   = 4'b0001 << ma_dat[1:0];
        dmem_wdat = {4{ma_rd2[7:0]}};
      end
      SZ_H: begin
        dmem_be   = ma_dat[1] ? 4'b1100 : 4'b0011;
        dmem_wdat = {2{ma_rd2[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction and extension.
  always_comb begin
    ld_half = ma_dat[1] ? dmem_rdat[31:16] : dmem_rdat[15:0];
    ld_byte = ma_dat[0] ? ld_half[15:8] : ld_half[7:0];
    case (size)
      SZ_B:    ld_data = ld_unsigned ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data = ld_unsigned ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = dmem_rdat;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wb_inst_d = wb_inst_q;
    wb_pc_d   = wb_pc_q;
    wb_dat_d  = wb_dat_q;
    dmem_req  = 1'b0;
    ma_stall  = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (misalign) begin
            wb_inst_d = BUBBLE;
          end else if (is_mem) begin
            dmem_req = 1'b1;
            if (dmem_gnt && is_store) begin
              wb_inst_d = ma_inst;
              wb_pc_d   = ma_pc;
              wb_dat_d  = ma_dat;
            end else begin
              ma_stall  = 1'b1;
              wb_inst_d = BUBBLE;
              state_d   = dmem_gnt ? RSP : REQ;
            end
          end else begin
            wb_inst_d = ma_inst;
            wb_pc_d   = ma_pc;
            wb_dat_d  = ma_dat;
          end
        end
        REQ: begin
          dmem_req = 1'b1;
          if (dmem_gnt && is_store) begin
            wb_inst_d = ma_inst;
            wb_pc_d   = ma_pc;
            wb_dat_d  = ma_dat;
            state_d   = IDLE;
          end else begin
            ma_stall  = 1'b1;
            wb_inst_d = BUBBLE;
            if (dmem_gnt) state_d = RSP;
          end
        end
        RSP: begin
          if (dmem_rvalid) begin
            wb_inst_d = ma_inst;
            wb_pc_d   = ma_pc;
            wb_dat_d  = ld_data;
            state_d   = IDLE;
          end else begin
            ma_stall  = 1'b1;
            wb_inst_d = BUBBLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wb_inst_q <= BUBBLE;
      wb_pc_q   <= 32'd0;
      wb_dat_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      wb_inst_q <= wb_inst_d;
      wb_pc_q   <= wb_pc_d;
      wb_dat_q  <= wb_dat_d;
    end
  end

`ifdef MA_MISALIGN_TRAP_EN
  logic misalign_q;
  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= (state_q == IDLE) && misalign;
  end
  assign ma_misalign = misalign_q;
`else
  assign ma_misalign = 1'b0;
`endif

  assign wb_inst = wb_inst_q;
  assign wb_pc   = wb_pc_q;
  assign wb_dat  = wb_dat_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Purpose : self-checking bench for mem_access_unit (directed table, corner sequences, random).
// Latency : drives one instruction at a time and checks every cycle until it retires.
// Backpressure: honours ma_stall by holding all ma_* inputs until the retiring cycle.
module tb_mem_access_unit;

  localparam logic [31:0] BUBBLE = 32'h0000_0013;
  localparam logic [6:0]  LOAD   = 7'b0000011;
  localparam logic [6:0]  STORE  = 7'b0100011;
  localparam logic [31:0] ADD    = 32'h0020_81B3;

  logic        clk, rst;
  logic [31:0] ma_inst, ma_pc, ma_dat, ma_rd2;
  logic        ma_stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdat, dmem_rdat;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] wb_inst, wb_pc, wb_dat;
  logic        ma_misalign;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_pc, exp_dat;   // last retired pc/data, expected to persist across bubbles

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .ma_inst(ma_inst), .ma_pc(ma_pc), .ma_dat(ma_dat), .ma_rd2(ma_rd2),
    .ma_stall(ma_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdat(dmem_wdat),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdat(dmem_rdat),
    .wb_inst(wb_inst), .wb_pc(wb_pc), .wb_dat(wb_dat),
    .ma_misalign(ma_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] opc);
    return {17'd0, f3, 5'd5, opc};
  endfunction

  // ---------------- reference model (plain arithmetic on the access rules) ----------------
  function automatic int unsigned nbytes(input bit ld, input logic [2:0] f3);
    if (ld) begin
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
    end
    if (f3 == 3'd0) return 1;
    if (f3 == 3'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_be(input int unsigned nb, input logic [31:0] a);
    int unsigned off = (a % 4) - ((a % 4) % nb);
    if (nb == 4) return 32'hF;
    return ((32'd1 << nb) - 1) << off;
  endfunction

  function automatic logic [31:0] ref_wdat(input int unsigned nb, input logic [31:0] d);
    if (nb == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (nb == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input int unsigned nb, input bit sgn,
                                           input logic [31:0] a, input logic [31:0] rdat);
    int unsigned off;
    logic [31:0] mask, v;
    if (nb == 4) return rdat;
    off  = (a % 4) - ((a % 4) % nb);
    mask = (32'd1 << (8 * nb)) - 1;
    v    = (rdat >> (8 * off)) & mask;
    if (sgn && v >= (32'd1 << (8 * nb - 1))) v = v | ~mask;
    return v;
  endfunction

  // ---------------- one instruction, checked cycle by cycle ----------------
  // gd: cycles without grant before the grant cycle; rd: RSP cycles before rvalid.
  task automatic run_inst(input string nm, input logic [31:0] inst, input logic [31:0] pc,
                          input logic [31:0] dat, input logic [31:0] rd2, input int gd,
                          input int rd, input logic [31:0] rdat, input logic [31:0] ebe,
                          input logic [31:0] ewdat, input logic [31:0] ewbd);
    bit ld, st;
    ld = (inst[6:0] == LOAD);
    st = (inst[6:0] == STORE);
    ma_inst = inst; ma_pc = pc; ma_dat = dat; ma_rd2 = rd2;
    if (!ld && !st) begin
      dmem_gnt = 1'($urandom_range(0, 1));
      dmem_rvalid = 1'($urandom_range(0, 1));
      dmem_rdat = $urandom;
      #1;
      chk({nm, "_stall"}, 32'(ma_stall), 32'd0);
      chk({nm, "_req"}, 32'(dmem_req), 32'd0);
      @(posedge clk); #1;
    end else begin
      for (int c = 0; c <= gd; c++) begin
        dmem_gnt    = (c == gd);
        dmem_rvalid = 1'($urandom_range(0, 1));
        dmem_rdat   = $urandom;
        #1;
        chk({nm, "_req"}, 32'(dmem_req), 32'd1);
        chk({nm, "_we"}, 32'(dmem_we), 32'(st));
        chk({nm, "_addr"}, dmem_addr, dat & 32'hFFFF_FFFC);
        if (st) begin
          chk({nm, "_be"}, 32'(dmem_be), ebe);
          chk({nm, "_wdat"}, dmem_wdat, ewdat);
        end
        chk({nm, "_stall_req"}, 32'(ma_stall), (st && c == gd) ? 32'd0 : 32'd1);
        @(posedge clk); #1;
        if (!(st && c == gd)) begin
          chk({nm, "_bubble"}, wb_inst, BUBBLE);
          chk({nm, "_hold_pc"}, wb_pc, exp_pc);
          chk({nm, "_hold_dat"}, wb_dat, exp_dat);
        end
      end
      if (ld) begin
        for (int c = 0; c <= rd; c++) begin
          dmem_gnt    = 1'($urandom_range(0, 1));
          dmem_rvalid = (c == rd);
          dmem_rdat   = (c == rd) ? rdat : $urandom;
          #1;
          chk({nm, "_req_rsp"}, 32'(dmem_req), 32'd0);
          chk({nm, "_stall_rsp"}, 32'(ma_stall), (c == rd) ? 32'd0 : 32'd1);
          @(posedge clk); #1;
          if (c != rd) chk({nm, "_bubble_rsp"}, wb_inst, BUBBLE);
        end
      end
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    exp_pc = pc; exp_dat = ewbd;
    chk({nm, "_wb_inst"}, wb_inst, inst);
    chk({nm, "_wb_pc"}, wb_pc, pc);
    chk({nm, "_wb_dat"}, wb_dat, ewbd);
    chk({nm, "_misalign"}, 32'(ma_misalign), 32'd0);
  endtask

  typedef struct {
    string       nm;
    logic [31:0] inst, pc, dat, rd2;
    int          gd, rd;
    logic [31:0] rdat, be, wdat, wbd;
  } vec_t;

  function automatic vec_t mkv(input string nm, input logic [31:0] inst, input logic [31:0] dat,
                               input logic [31:0] rd2, input int gd, input int rd,
                               input logic [31:0] rdat, input logic [31:0] be,
                               input logic [31:0] wdat, input logic [31:0] wbd);
    vec_t v;
    v.nm = nm; v.inst = inst; v.pc = 32'h1000 + dat; v.dat = dat; v.rd2 = rd2;
    v.gd = gd; v.rd = rd; v.rdat = rdat; v.be = be; v.wdat = wdat; v.wbd = wbd;
    return v;
  endfunction

  vec_t        tbl[$];
  logic [31:0] r_inst, r_dat, r_rd2, r_rdat, r_wbd;
  logic [2:0]  r_f3;
  int unsigned r_kind, r_nb;

  initial begin
    tbl.push_back(mkv("add",   ADD,              32'h1234, 32'h0,        0, 0, 32'h0,        32'h0, 32'h0,        32'h1234));
    tbl.push_back(mkv("sb103", mk(3'd0, STORE),  32'h103,  32'hAB,       0, 0, 32'h0,        32'h8, 32'hABABABAB, 32'h103));
    tbl.push_back(mkv("lb101", mk(3'd0, LOAD),   32'h101,  32'h0,        2, 2, 32'h0000F000, 32'h0, 32'h0,        32'hFFFFFFF0));
    tbl.push_back(mkv("lhu202",mk(3'd5, LOAD),   32'h202,  32'h0,        0, 0, 32'h80010000, 32'h0, 32'h0,        32'h00008001));
    tbl.push_back(mkv("sh202", mk(3'd1, STORE),  32'h202,  32'h1234BEEF, 1, 0, 32'h0,        32'hC, 32'hBEEFBEEF, 32'h202));
    tbl.push_back(mkv("sh200", mk(3'd1, STORE),  32'h200,  32'h00005A5A, 0, 0, 32'h0,        32'h3, 32'h5A5A5A5A, 32'h200));
    tbl.push_back(mkv("sw200", mk(3'd2, STORE),  32'h200,  32'hDEADBEEF, 3, 0, 32'h0,        32'hF, 32'hDEADBEEF, 32'h200));
    tbl.push_back(mkv("lh200", mk(3'd1, LOAD),   32'h200,  32'h0,        1, 1, 32'h00008001, 32'h0, 32'h0,        32'hFFFF8001));
    tbl.push_back(mkv("lbu103",mk(3'd4, LOAD),   32'h103,  32'h0,        0, 3, 32'h80000000, 32'h0, 32'h0,        32'h00000080));
    tbl.push_back(mkv("lw204", mk(3'd2, LOAD),   32'h204,  32'h0,        0, 0, 32'hCAFEF00D, 32'h0, 32'h0,        32'hCAFEF00D));
    tbl.push_back(mkv("st_f7", mk(3'd7, STORE),  32'h30C,  32'h01234567, 0, 0, 32'h0,        32'hF, 32'h01234567, 32'h30C));
    tbl.push_back(mkv("ld_f6", mk(3'd6, LOAD),   32'h308,  32'h0,        1, 0, 32'h89ABCDEF, 32'h0, 32'h0,        32'h89ABCDEF));

    // reset: request-free and stall-free even with a load presented
    rst = 1'b1; ma_inst = mk(3'd2, LOAD); ma_pc = 32'h0; ma_dat = 32'h40; ma_rd2 = 32'h0;
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdat = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(ma_stall), 32'd0);
    @(posedge clk); #1;
    chk("rst_wb_inst", wb_inst, BUBBLE);
    chk("rst_wb_pc", wb_pc, 32'd0);
    chk("rst_wb_dat", wb_dat, 32'd0);
    chk("rst_misalign", 32'(ma_misalign), 32'd0);
    rst = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    exp_pc = 32'd0; exp_dat = 32'd0;

    foreach (tbl[i])
      run_inst(tbl[i].nm, tbl[i].inst, tbl[i].pc, tbl[i].dat, tbl[i].rd2, tbl[i].gd,
               tbl[i].rd, tbl[i].rdat, tbl[i].be, tbl[i].wdat, tbl[i].wbd);

    // reset while waiting for a load response; a late rvalid must not land
    ma_inst = mk(3'd2, LOAD); ma_pc = 32'h500; ma_dat = 32'h300; dmem_gnt = 1'b1;
    #1 chk("rr_req", 32'(dmem_req), 32'd1);
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    #1 chk("rr_rsp_stall", 32'(ma_stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("rr_rst_req", 32'(dmem_req), 32'd0);
    chk("rr_rst_stall", 32'(ma_stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; exp_pc = 32'd0; exp_dat = 32'd0;
    chk("rr_wb_inst", wb_inst, BUBBLE);
    chk("rr_wb_pc", wb_pc, 32'd0);
    chk("rr_wb_dat", wb_dat, 32'd0);
    ma_inst = ADD; ma_pc = 32'h400; ma_dat = 32'h66;
    #1 chk("rr_idle_stall", 32'(ma_stall), 32'd0);
    @(posedge clk); #1;
    chk("rr_add_dat", wb_dat, 32'h66);
    dmem_rvalid = 1'b1; dmem_rdat = 32'hBAD0_BAD0; ma_pc = 32'h404; ma_dat = 32'h77;
    #1;
    chk("rr_late_stall", 32'(ma_stall), 32'd0);
    chk("rr_late_req", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    chk("rr_late_wb_inst", wb_inst, ADD);
    chk("rr_late_wb_dat", wb_dat, 32'h77);
    exp_pc = 32'h404; exp_dat = 32'h77;

`ifdef MA_MISALIGN_TRAP_EN
    ma_inst = mk(3'd2, LOAD); ma_pc = 32'h600; ma_dat = 32'h6; dmem_gnt = 1'b1;
    #1;
    chk("mis_lw_req", 32'(dmem_req), 32'd0);
    chk("mis_lw_stall", 32'(ma_stall), 32'd0);
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    chk("mis_lw_flag", 32'(ma_misalign), 32'd1);
    chk("mis_lw_bubble", wb_inst, BUBBLE);
    chk("mis_lw_pc", wb_pc, exp_pc);
    ma_inst = ADD; ma_pc = 32'h604; ma_dat = 32'h88;
    @(posedge clk); #1;
    chk("mis_clear", 32'(ma_misalign), 32'd0);
    chk("mis_next_inst", wb_inst, ADD);
    exp_pc = 32'h604; exp_dat = 32'h88;
    ma_inst = mk(3'd1, STORE); ma_pc = 32'h608; ma_dat = 32'h201;
    #1 chk("mis_sh_req", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    chk("mis_sh_flag", 32'(ma_misalign), 32'd1);
    chk("mis_sh_dat", wb_dat, exp_dat);
`else
    run_inst("lw_mis", mk(3'd2, LOAD), 32'h600, 32'h6, 32'h0, 0, 0, 32'h11223344,
             32'h0, 32'h0, 32'h11223344);
    run_inst("sh_mis", mk(3'd1, STORE), 32'h604, 32'h201, 32'h0000C3D2, 1, 0, 32'h0,
             32'h3, 32'hC3D2C3D2, 32'h201);
`endif

    // random instruction mix against the reference model
    for (int n = 0; n < 150; n++) begin
      r_kind = $urandom_range(0, 2);
      r_f3   = 3'($urandom_range(0, 7));
      r_dat  = $urandom;
      r_rd2  = $urandom;
      r_rdat = $urandom;
      r_inst = $urandom;
      r_inst[14:12] = r_f3;
      if (r_kind == 0)      r_inst[6:0] = LOAD;
      else if (r_kind == 1) r_inst[6:0] = STORE;
      else if (r_inst[6:0] == LOAD || r_inst[6:0] == STORE) r_inst[2] = 1'b1;
      r_nb = nbytes(r_kind == 0, r_f3);
`ifdef MA_MISALIGN_TRAP_EN
      if (r_kind != 2) r_dat = r_dat & ~(r_nb - 1);
`endif
      if (r_kind == 0) r_wbd = ref_load(r_nb, r_f3[2] == 1'b0, r_dat, r_rdat);
      else             r_wbd = r_dat;
      run_inst($sformatf("rnd%0d", n), r_inst, $urandom, r_dat, r_rd2,
               $urandom_range(0, 3), $urandom_range(0, 3), r_rdat,
               ref_be(r_nb, r_dat), ref_wdat(r_nb, r_rd2), r_wbd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports ma_inst/ma_pc/ma_dat/ma_rd2  in  32 each  instruction, PC, ALU result (address), store data from execute.
REQ-004 SHALL have port ma_stall  out  1  high = upstream holds all ma_* inputs stable.
REQ-005 SHALL have ports dmem_req  out 1; dmem_we  out 1; dmem_addr  out 32; dmem_be  out 4; dmem_wdat  out 32  data-memory request.
REQ-006 SHALL have ports dmem_gnt  in 1; dmem_rvalid  in 1; dmem_rdat  in 32  data-memory grant and read response.
REQ-007 SHALL have ports wb_inst/wb_pc/wb_dat  out  32 each  registered outputs to writeback.
REQ-008 SHALL have port ma_misalign  out  1  registered misaligned-access flag (MA_MISALIGN_TRAP_EN only, else tied 0).

Function
REQ-009 SHALL decode ma_inst[6:0]: 0000011 = load, 0100011 = store, else pass-through; size/sign from ma_inst[14:12].
REQ-010 SHALL implement FSM states IDLE, REQ, RSP.
REQ-011 IDLE + pass-through: SHALL register wb_inst=ma_inst, wb_pc=ma_pc, wb_dat=ma_dat next edge; ma_stall=0; latency 1 cycle.
REQ-012 IDLE + load/store: SHALL drive dmem_req=1 combinationally and ma_stall=1; dmem_gnt=1 same cycle -> store completes, load -> RSP; dmem_gnt=0 -> REQ.
REQ-013 REQ: SHALL hold dmem_req=1 with unchanged addr/be/wdat/we until dmem_gnt; then store -> IDLE (completion), load -> RSP.
REQ-014 RSP: SHALL drive dmem_req=0, ma_stall=1 until dmem_rvalid; on rvalid, ma_stall=0 that cycle, result registered, -> IDLE.
REQ-015 Store completion cycle SHALL deassert ma_stall; next edge wb_inst=store inst, wb_dat=ma_dat.
REQ-016 While ma_stall=1 (non-completion cycles), SHALL register wb_inst=BUBBLE (0x00000013), wb_pc/wb_dat unchanged.
REQ-017 dmem_addr SHALL be {ma_dat[31:2],2'b00}; dmem_we=1 only for stores.
REQ-018 Store be: SB -> 1 lane at addr[1:0]; SH -> 4'b0011 (addr[1]=0) or 4'b1100; SW -> 4'b1111.
REQ-019 Store wdat: SB -> byte replicated x4; SH -> halfword replicated x2; SW -> ma_rd2.
REQ-020 Load data: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged; captured into wb_dat on rvalid edge.
REQ-021 dmem_rvalid in IDLE/REQ SHALL be ignored; dmem_gnt outside a request SHALL be ignored.
REQ-022 funct3 values other than valid load/store sizes SHALL be treated as word access.

Reset
REQ-023 rst=1 SHALL force state=IDLE, wb_inst=BUBBLE, wb_pc=0, wb_dat=0, ma_misalign=0 at next edge.
REQ-024 rst mid-transaction (REQ/RSP) SHALL abandon it; a late rvalid after reset SHALL be ignored.
REQ-025 During rst, dmem_req SHALL be 0 and ma_stall SHALL be 0.

Configuration
REQ-026 Macro MA_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL issue no dmem_req, no stall, register wb_inst=BUBBLE and ma_misalign=1 for one cycle.
REQ-027 MA_MISALIGN_TRAP_EN undefined: misaligned low address bits SHALL be ignored (access performed aligned per REQ-017/018), ma_misalign constant 0.

Verification
REQ-028 ADD inst, ma_dat=0x1234 -> next cycle wb_inst=inst, wb_dat=0x1234, ma_stall never high.
REQ-029 SB addr 0x103, rd2=0x000000AB, gnt same cycle -> dmem_be=4'b1000, wdat=0xABABABAB, we=1, 1-cycle transaction.
REQ-030 LB addr 0x101, gnt after 2 cycles, rvalid 3 cycles later with rdat=0x0000F000 -> wb_dat=0xFFFFFFF0, stall held throughout, BUBBLEs emitted meanwhile.
REQ-031 LHU addr 0x202, rdat=0x8001_0000 -> wb_dat=0x00008001.
REQ-032 rst asserted in RSP, rvalid 1 cycle after rst release -> IDLE, wb_inst=BUBBLE, rvalid ignored.
REQ-033 MA_MISALIGN_TRAP_EN: LW addr 0x6 -> dmem_req=0, ma_misalign=1 one cycle, wb_inst=BUBBLE.
